// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: IDLE/REQ/WAIT/DONE fetch FSM with
// redirect capture, wait-state timeout and IR field decode.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ack,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [3:0]  opcode,
  output logic [2:0]  ra,
  output logic [2:0]  rb,
  output logic [2:0]  rc,
  output logic [1:0]  funct,
  output logic [5:0]  imm6,
  output logic [8:0]  imm9,
  output logic [15:0] ir_pc,
  output logic [15:0] pc_plus1,
  output logic        ir_valid,
  output logic        stall,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] ir_pc_q, ir_pc_d;
  logic [15:0] pp1_q, pp1_d;
  logic        ir_valid_q, ir_valid_d;
  logic        err_q, err_d;
  logic        pend_q, pend_d;
  logic [15:0] pend_pc_q, pend_pc_d;
  logic [7:0]  wcnt_q, wcnt_d;
  logic        req_q, req_d;

  logic        busy;
  logic        latch;
  logic        tmo;
  logic        redir_any;
  logic [15:0] redir_tgt;
  logic [15:0] pc_inc;

  assign busy      = (state_q == S_REQ) || (state_q == S_WAIT);
  assign latch     = busy && imem_ack;
  assign tmo       = (state_q == S_WAIT) && !imem_ack &&
                     (({1'b0, wcnt_q} + 9'd1) >= {1'b0, TIMEOUT});
  assign redir_any = redirect || pend_q;
  assign redir_tgt = redirect ? redirect_pc : pend_pc_q;
  assign pc_inc    = pc_q + 16'd1;

  // Next-state: FSM transitions, IR latch, redirect and timeout handling
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    pp1_d      = pp1_q;
    ir_valid_d = ir_valid_q;
    err_d      = err_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    wcnt_d     = wcnt_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end
        if (fetch_en) begin
          state_d = S_REQ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ, S_WAIT: begin
        if (latch) begin
          ir_d       = imem_rdata;
          ir_pc_d    = pc_q;
          pp1_d      = pc_inc;
          ir_valid_d = 1'b1;
          pc_d       = redir_any ? redir_tgt : pc_inc;
          pend_d     = 1'b0;
          state_d    = S_DONE;
        end else if (tmo) begin
          err_d   = 1'b1;
          if (redir_any) begin
            pc_d = redir_tgt;
          end
          pend_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (redirect) begin
            pend_d    = 1'b1;
            pend_pc_d = redirect_pc;
          end
          if (state_q == S_REQ) begin
            state_d = S_WAIT;
            wcnt_d  = 8'd0;
          end else begin
            wcnt_d  = wcnt_q + 8'd1;
          end
        end
      end
    endcase
    // A new fetch invalidates IR until its own latch
    if (state_d == S_REQ) begin
      ir_valid_d = 1'b0;
      wcnt_d     = 8'd0;
    end
    req_d = (state_d == S_REQ) || (state_d == S_WAIT);
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= 16'h0000;
      ir_pc_q    <= 16'h0000;
      pp1_q      <= 16'h0000;
      ir_valid_q <= 1'b0;
      err_q      <= 1'b0;
      pend_q     <= 1'b0;
      pend_pc_q  <= 16'h0000;
      wcnt_q     <= 8'd0;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      pp1_q      <= pp1_d;
      ir_valid_q <= ir_valid_d;
      err_q      <= err_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      wcnt_q     <= wcnt_d;
      req_q      <= req_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign stall     = !reset &&
                     (req_q || ((state_q == S_IDLE) && fetch_en));
  assign ir_valid  = ir_valid_q;
  assign fetch_err = err_q;
  assign ir_pc     = ir_pc_q;
  assign pc_plus1  = pp1_q;

  assign opcode = ir_q[15:12];
  assign ra     = ir_q[11:9];
  assign rb     = ir_q[8:6];
  assign rc     = ir_q[5:3];
  assign funct  = ir_q[1:0];
  assign imm6   = ir_q[5:0];
  assign imm9   = ir_q[8:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized scoreboard bench for instr_fetch_unit.
// Stimulus pushes expected IR contents; a monitor checks them.
module tb_instr_fetch_unit;

  localparam logic [15:0] RPC = 16'h0000;
  localparam logic [7:0]  TMO = 8'd255;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [3:0]  opcode;
  logic [2:0]  ra, rb, rc;
  logic [1:0]  funct;
  logic [5:0]  imm6;
  logic [8:0]  imm9;
  logic [15:0] ir_pc;
  logic [15:0] pc_plus1;
  logic        ir_valid;
  logic        stall;
  logic        fetch_err;

  instr_fetch_unit #(.RESET_PC(RPC), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .opcode(opcode), .ra(ra), .rb(rb), .rc(rc),
    .funct(funct), .imm6(imm6), .imm9(imm9),
    .ir_pc(ir_pc), .pc_plus1(pc_plus1),
    .ir_valid(ir_valid), .stall(stall), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] word;
    logic [15:0] ipc;
    logic [15:0] pp1;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_pc;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic logic [29:0] dec(input logic [15:0] w);
    return {w[15:12], w[11:9], w[8:6], w[5:3], w[1:0], w[5:0], w[8:0]};
  endfunction

  // Monitor: pop on every new completed fetch, else IR must hold
  logic [15:0] cur_w = 16'h0, cur_pc = 16'h0, cur_p1 = 16'h0;
  logic        prev_v = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      cur_w = 16'h0; cur_pc = 16'h0; cur_p1 = 16'h0;
      prev_v = 1'b0;
    end else begin
      if (ir_valid && !prev_v) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_fetch actual=%h expected=none",
                   ir_pc);
        end else begin
          e = sb.pop_front();
          cur_w = e.word; cur_pc = e.ipc; cur_p1 = e.pp1;
        end
      end
      prev_v = ir_valid;
    end
    chk("ir_fields", {2'b0, opcode, ra, rb, rc, funct, imm6, imm9},
        {2'b0, dec(cur_w)});
    chk("ir_pc", {16'h0, ir_pc}, {16'h0, cur_pc});
    chk("pc_plus1", {16'h0, pc_plus1}, {16'h0, cur_p1});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_redir(input logic [15:0] t);
    redirect = 1'b1;
    redirect_pc = t;
    @(posedge clk); #1;
    redirect = 1'b0;
    model_pc = t;
  endtask

  // One fetch from IDLE; ack arrives on request cycle dly.
  // Redirects: random with rprob percent per cycle, or forced at fk.
  task automatic fetch(input logic [15:0] word, input int dly,
                       input int rprob, input int fk,
                       input logic [15:0] ft);
    logic [15:0] nxt;
    exp_t        e;
    bit          rd;
    nxt = model_pc + 16'd1;
    fetch_en = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k <= dly; k++) begin
      chk("req_hi", {31'b0, imem_req}, 32'd1);
      chk("addr", {16'h0, imem_addr}, {16'h0, model_pc});
      chk("stall_hi", {31'b0, stall}, 32'd1);
      chk("valid_lo", {31'b0, ir_valid}, 32'd0);
      rd = (k == fk) || (int'($urandom_range(99)) < rprob);
      redirect = rd;
      redirect_pc = (k == fk) ? ft : 16'($urandom);
      if (rd) nxt = redirect_pc;
      imem_ack = (k == dly);
      imem_rdata = (k == dly) ? word : 16'($urandom);
      @(posedge clk); #1;
    end
    e.word = word;
    e.ipc = model_pc;
    e.pp1 = model_pc + 16'd1;
    sb.push_back(e);
    model_pc = nxt;
    chk("valid_hi", {31'b0, ir_valid}, 32'd1);
    redirect = 1'b0;
    fetch_en = 1'b0;
    imem_ack = 1'($urandom);
    imem_rdata = 16'($urandom);
    @(posedge clk); #1;
    imem_ack = 1'b0;
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    chk("idle_stall", {31'b0, stall}, 32'd0);
  endtask

  // No ack at all: abort after one REQ plus TMO WAIT cycles
  task automatic timeout_fetch(input int fk, input logic [15:0] ft);
    logic [15:0] nxt;
    nxt = model_pc;
    fetch_en = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k <= int'(TMO); k++) begin
      chk("tmo_req", {31'b0, imem_req}, 32'd1);
      chk("tmo_addr", {16'h0, imem_addr}, {16'h0, model_pc});
      redirect = (k == fk);
      redirect_pc = ft;
      if (k == fk) nxt = ft;
      imem_ack = 1'b0;
      imem_rdata = 16'($urandom);
      @(posedge clk); #1;
    end
    redirect = 1'b0;
    chk("tmo_req_lo", {31'b0, imem_req}, 32'd0);
    chk("tmo_err", {31'b0, fetch_err}, 32'd1);
    chk("tmo_idle_stall", {31'b0, stall}, 32'd1);
    chk("tmo_valid", {31'b0, ir_valid}, 32'd0);
    fetch_en = 1'b0;
    model_pc = nxt;
    @(posedge clk); #1;
    chk("tmo_stay_idle", {31'b0, stall}, 32'd0);
    chk("tmo_addr_after", {16'h0, imem_addr}, {16'h0, model_pc});
  endtask

  initial begin
    reset = 1'b1;
    fetch_en = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0;
    imem_rdata = 16'h0;
    imem_ack = 1'b0;
    model_pc = RPC;
    repeat (3) @(posedge clk);
    #1;
    fetch_en = 1'b1;
    #1;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    fetch_en = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, ir_valid}, 32'd0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);
    chk("rst_addr", {16'h0, imem_addr}, {16'h0, RPC});

    fetch(16'h0A48, 0, 0, -1, 16'h0);
    fetch(16'h1234, 3, 0, -1, 16'h0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0) idle_redir(16'($urandom));
      fetch(16'($urandom), int'($urandom_range(5)), 20, -1, 16'h0);
    end

    idle_redir(16'hFFFF);
    fetch(16'hD005, 0, 0, -1, 16'h0);
    fetch(16'($urandom), 0, 0, -1, 16'h0);

    idle_redir(16'h0010);
    fetch(16'($urandom), 3, 0, 1, 16'h0040);
    fetch(16'($urandom), 1, 0, -1, 16'h0);

    timeout_fetch(-1, 16'h0);
    timeout_fetch(10, 16'h0200);
    fetch(16'($urandom), 2, 0, -1, 16'h0);
    chk("err_sticky", {31'b0, fetch_err}, 32'd1);

    fetch_en = 1'b1;
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_mid_req", {31'b0, imem_req}, 32'd0);
    chk("rst_mid_stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    fetch_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    imem_ack = 1'b1;
    imem_rdata = 16'hBEEF;
    @(posedge clk); #1;
    imem_ack = 1'b0;
    model_pc = RPC;
    chk("late_ack_req", {31'b0, imem_req}, 32'd0);
    chk("late_ack_valid", {31'b0, ir_valid}, 32'd0);
    chk("rst_err_clr", {31'b0, fetch_err}, 32'd0);
    chk("rst_pc", {16'h0, imem_addr}, {16'h0, RPC});

    for (int i = 0; i < 8; i++) begin
      fetch(16'($urandom), int'($urandom_range(4)), 30, -1, 16'h0);
    end

    @(posedge clk); #1;
    chk("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
